// File: rtl/iterative_shifter.sv
// ---------------------------------------------------------------------------
// iterative_shifter
//
// Multi-cycle shift unit that moves the operand one bit position per clock.
// It replaces the combinational barrel shifter where area matters. Its
// results, including the carry, match the barrel shifter bit for bit.
//
// Ports:
//   CLK              rising-edge clock
//   RESET            synchronous, active-high reset; aborts any operation
//   Start            request strobe, only sampled while not Busy
//   Sh               00=LSL, 01=LSR, 10=ASR, 11=ROR
//   Shamt5           shift amount, 0..WIDTH-1
//   ShIn             operand
//   current_CFlag    incoming carry flag
//   Busy             high while a request is in progress
//   Done             one-cycle completion pulse
//   ShOut            result, held until the next accepted Start
//   Shifter_carryOut carry result, held with ShOut
//
// Build option:
//   ITERATIVE_SHIFTER_RRX_EN - when defined, ROR by 0 performs RRX
//   (rotate right by one through the carry flag).
// ---------------------------------------------------------------------------
module iterative_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               Start,
    input  logic [1:0]         Sh,
    input  logic [SHAMT_W-1:0] Shamt5,
    input  logic [WIDTH-1:0]   ShIn,
    input  logic               current_CFlag,
    output logic               Busy,
    output logic               Done,
    output logic [WIDTH-1:0]   ShOut,
    output logic               Shifter_carryOut
);

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t             state;
    logic [1:0]         opReg;
    logic [SHAMT_W-1:0] count;

    // One-bit step of the selected operation; returns {carry, result}.
    function automatic logic [WIDTH:0] stepOnce(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] r);
        logic [WIDTH:0] res;
        unique case (op)
            OP_LSL:  res = {r[WIDTH-1], r << 1};
            OP_LSR:  res = {r[0], 1'b0, r[WIDTH-1:1]};
            OP_ASR:  res = {r[0], r[WIDTH-1], r[WIDTH-1:1]};
            OP_ROR:  res = {r[0], r[0], r[WIDTH-1:1]};
            default: res = {1'b0, r};
        endcase
        return res;
    endfunction

    // ShOut and Shifter_carryOut double as the working registers, so every
    // output comes straight from a flop.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state            <= IDLE;
            Busy             <= 1'b0;
            Done             <= 1'b0;
            ShOut            <= '0;
            Shifter_carryOut <= 1'b0;
            count            <= '0;
            opReg            <= OP_LSL;
        end else begin
            case (state)
                IDLE, DONE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        // All operands are latched here, so later input
                        // changes cannot disturb the running operation.
                        ShOut            <= ShIn;
                        Shifter_carryOut <= current_CFlag;
                        opReg            <= Sh;
                        count            <= Shamt5;
                        Busy             <= 1'b1;
                        state            <= SHIFT;
                    end else begin
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    if (count == '0) begin
                        // Shift by zero passes the operand and carry through.
                        // With RRX enabled, ROR #0 instead rotates once
                        // through the carry.
`ifdef ITERATIVE_SHIFTER_RRX_EN
                        if (opReg == OP_ROR)
                            {Shifter_carryOut, ShOut} <=
                                {ShOut[0], Shifter_carryOut, ShOut[WIDTH-1:1]};
`endif
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        {Shifter_carryOut, ShOut} <= stepOnce(opReg, ShOut);
                        count <= count - SHAMT_W'(1);
                        // The step that empties the counter also finishes.
                        if (count == SHAMT_W'(1)) begin
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                default: begin
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
